cpu_trace_tx: RTL and testbench
===============================

# cpu_trace_tx

Trace transmitter for the 4-bit CPU. It samples the core's architectural state (PC, halt, R0–R3, current instruction) on qualified cycles and buffers the samples in a small record FIFO. It serializes each record as a 5-byte UART 8N1 frame on a single `tx` pin, so a bench or host can reconstruct the execution trace from the serial stream instead of probing internal nets. It sits beside the CPU at the top level and observes the core's outputs only; it never drives the core.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit. Legal values are ≥2.
- `DEPTH`, default 8: record FIFO depth. Must be a power of two, ≥2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset. Reset is synchronous and active-high.
- `sample_en`  in  1  capture request for this cycle.
- `halt`  in  1  CPU halt flag.
- `pc_in`  in  4  CPU program counter.
- `r0_in`, `r1_in`, `r2_in`, `r3_in`  in  4 each  CPU register values.
- `instr_in`  in  8  current instruction word.
- `tx`  out  1  serial output, idle high.
- `tx_busy`  out  1  high while a frame is being shifted out.
- `overflow`  out  1  sticky; set when a capture is dropped because the FIFO is full.
- `done`  out  1  high once the halt record has been fully transmitted and the FIFO is empty.

## Operation
- **Record format**, packed at capture time, 32 bits:
  - B1 = {halt, 3'b000, pc}
  - B2 = {r1, r0}
  - B3 = {r3, r2}
  - B4 = instr
- **Frame**: sync byte 0xA5, then B1, B2, B3, B4.
  - Each byte is 8N1: start bit 0, data LSB first, stop bit 1.
  - Bytes within a frame go back to back with no idle gap.
- **Capture**:
  - A record is written when `sample_en`=1 and FIFO not full and `stopped`=0.
  - `stopped` sets when a record with halt=1 is written. All later captures are silently ignored; this is not an overflow.
  - If `sample_en`=1 and the FIFO is full and `stopped`=0, the record is dropped and `overflow` sets.
  - Full is the state at the start of the cycle. A simultaneous pop does not make room for a push in the same cycle.
- **Transmit FSM** states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop the head record, set byte index = 0 (sync byte), go to START.
  - START: drive `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift 8 bits, CLKS_PER_BIT cycles each, then go to STOP.
  - STOP: drive `tx`=1 for CLKS_PER_BIT cycles. If byte index < 4: increment it and go to START. Else go to IDLE.
  - The bit timer is a counter 0..CLKS_PER_BIT-1. It reloads at every bit boundary.
- **Outputs**:
  - `tx_busy` = (state ≠ IDLE).
  - `done` = `stopped` & FIFO empty & state==IDLE.
- **Pointers**: FIFO pointers wrap modulo DEPTH. An extra MSB distinguishes full from empty.

## Timing
- Reset values:
  - `tx`=1, `tx_busy`=0, `overflow`=0, `done`=0.
  - FIFO empty, `stopped`=0, FSM in IDLE.
- Reset mid-frame: at the reset edge `tx` returns to 1. The partial frame and all buffered records are discarded.
- Capture latency:
  - Record sampled at edge N is visible in the FIFO after edge N.
  - FSM pops it at edge N+1 if IDLE.
  - `tx` falls to 0 and `tx_busy` rises after edge N+1.
- Frame length: 50·CLKS_PER_BIT cycles from start-bit fall to the end of the last stop bit.
  - After the final stop bit, the FSM spends exactly 1 cycle in IDLE before the next pop.
  - Record-to-record period under back-pressure is therefore 50·CLKS_PER_BIT+1 cycles.
- Flag timing:
  - `overflow` asserts the cycle after the dropping edge and holds until reset.
  - `done` asserts the cycle the FSM re-enters IDLE after the halt record, provided the FIFO is empty.

## Test plan
- **Single record**, CLKS_PER_BIT=4.
  - Stimulus: one sample with pc=3, halt=0, r0=1, r1=2, r2=3, r3=4, instr=0x5C.
  - Required: decoded bytes A5, 03, 21, 43, 5C; `tx` low 2 cycles after the sample edge; `tx_busy` high for exactly 200 cycles.
- **Back-to-back overflow**, DEPTH=8.
  - Stimulus: `sample_en` high 12 consecutive cycles.
  - Required: the first 9 records are accepted (one popped immediately, 8 buffered); `overflow` sets on the 10th; exactly 9 frames are emitted in order, each separated by 1 idle cycle.
- **Halt stop**.
  - Stimulus: samples with halt=0, 0, 1, then 5 more with halt=1.
  - Required: exactly 3 frames; the third has B1 bit7=1; `overflow` stays 0; `done` rises after the third stop bit.
- **Reset mid-frame**.
  - Stimulus: assert `rst` during DATA of byte B2 with 3 records queued.
  - Required: `tx`=1 and `tx_busy`=0 the cycle after; no further frames until new samples arrive.
- **Full + pop same cycle**.
  - Stimulus: with the FIFO full, push on the exact cycle the FSM pops.
  - Required: the push is dropped and `overflow`=1.
- **CLKS_PER_BIT=2**.
  - Stimulus: the single-record case.
  - Required: same bytes, 100-cycle frame.

Source files
------------

// File: rtl/cpu_trace_tx.sv
// cpu_trace_tx: trace transmitter for the 4-bit CPU.
// Captures {halt, pc, r0..r3, instr} on qualified cycles into a record FIFO and
// serializes each record as a UART 8N1 frame: 0xA5, B1, B2, B3, B4, back to back.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_sample_en  capture request for this cycle
//   i_halt       CPU halt flag
//   i_pc_in      CPU program counter (4b)
//   i_r0_in..i_r3_in  CPU registers (4b each)
//   i_instr_in   current instruction (8b)
//   o_tx         serial output, idle high
//   o_tx_busy    high while a frame is being shifted out
//   o_overflow   sticky, a capture was dropped on a full FIFO
//   o_done       halt record fully sent and nothing left to send
module cpu_trace_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sample_en,
  input  logic       i_halt,
  input  logic [3:0] i_pc_in,
  input  logic [3:0] i_r0_in,
  input  logic [3:0] i_r1_in,
  input  logic [3:0] i_r2_in,
  input  logic [3:0] i_r3_in,
  input  logic [7:0] i_instr_in,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_overflow,
  output logic       o_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_stopped, r_overflow;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [2:0]    r_byte_idx;
  logic [7:0]    r_shift;
  logic [31:0]   r_rec;     // record bytes not yet loaded into r_shift, B1 in the top byte
  logic          r_tx;

  logic w_empty, w_full, w_push, w_bit_end;

  // Extra pointer MSB: equal low bits with differing MSB means full.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Full is judged on the start-of-cycle pointers, so a same-cycle pop never frees a slot.
  assign w_push    = i_sample_en & ~w_full & ~r_stopped;
  assign w_bit_end = (r_timer == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= {i_halt, 3'b000, i_pc_in, i_r1_in, i_r0_in,
                                  i_r3_in, i_r2_in, i_instr_in};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_stopped  <= 1'b0;
      r_overflow <= 1'b0;
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_rec      <= '0;
      r_tx       <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (i_halt) r_stopped <= 1'b1;
      end
      if (i_sample_en && w_full && !r_stopped) r_overflow <= 1'b1;

      if (r_state != S_IDLE)
        r_timer <= w_bit_end ? '0 : r_timer + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (!w_empty) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_rec      <= r_mem[r_rd_ptr[AW-1:0]];
            r_shift    <= 8'hA5;
            r_byte_idx <= '0;
            r_tx       <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_byte_idx < 3'd4) begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_shift    <= r_rec[31:24];
              r_rec      <= {r_rec[23:0], 8'h00};
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx       = r_tx;
  assign o_tx_busy  = (r_state != S_IDLE);
  assign o_overflow = r_overflow;
  assign o_done     = r_stopped & w_empty & (r_state == S_IDLE);
endmodule

// File: tb/tb_cpu_trace_tx.sv
// Bench for cpu_trace_tx. Two instances (CLKS_PER_BIT 4 and 2) share the stimulus.
// The reference model tracks FIFO occupancy, the time each frame occupies the line,
// and the byte stream each accepted record must produce; a UART receiver decodes tx.
module tb_cpu_trace_tx;
  localparam int DEPTH = 8;
  localparam int CPB0  = 4;
  localparam int CPB1  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0, halt = 1'b0;
  logic [3:0] pc = '0, r0 = '0, r1 = '0, r2 = '0, r3 = '0;
  logic [7:0] instr = '0;
  logic [1:0] tx, busy, ovf, done;

  always #5 clk = ~clk;

  cpu_trace_tx #(.CLKS_PER_BIT(CPB0), .DEPTH(DEPTH)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_sample_en(sample_en), .i_halt(halt),
    .i_pc_in(pc), .i_r0_in(r0), .i_r1_in(r1), .i_r2_in(r2), .i_r3_in(r3),
    .i_instr_in(instr),
    .o_tx(tx[0]), .o_tx_busy(busy[0]), .o_overflow(ovf[0]), .o_done(done[0]));

  cpu_trace_tx #(.CLKS_PER_BIT(CPB1), .DEPTH(DEPTH)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_sample_en(sample_en), .i_halt(halt),
    .i_pc_in(pc), .i_r0_in(r0), .i_r1_in(r1), .i_r2_in(r2), .i_r3_in(r3),
    .i_instr_in(instr),
    .o_tx(tx[1]), .o_tx_busy(busy[1]), .o_overflow(ovf[1]), .o_done(done[1]));

  int n_chk = 0;
  int n_fail = 0;

  // reference model state, one slot per instance
  int         cpb[2] = '{CPB0, CPB1};
  int         occ[2], free_cyc[2], busy_cnt[2], rx_n[2], rx_cnt[2];
  bit         stopped[2], ovf_m[2], rx_act[2];
  logic [7:0] rx_byte[2];
  logic [7:0] expq0[$], expq1[$];
  logic [7:0] rx_log0[$], rx_log1[$];
  logic [7:0] gold[5] = '{8'hA5, 8'h03, 8'h21, 8'h43, 8'h5C};

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  task automatic push_exp(input int k, input logic [7:0] b);
    if (k == 0) expq0.push_back(b); else expq1.push_back(b);
  endtask

  task automatic take_exp(input int k, output logic [7:0] b, output bit ok);
    ok = 0; b = '0;
    if (k == 0) begin
      if (expq0.size() > 0) begin b = expq0.pop_front(); ok = 1; end
    end else begin
      if (expq1.size() > 0) begin b = expq1.pop_front(); ok = 1; end
    end
  endtask

  function automatic int exp_size(input int k);
    return (k == 0) ? expq0.size() : expq1.size();
  endfunction

  task automatic clear_k(input int k);
    if (k == 0) begin expq0.delete(); rx_log0.delete(); end
    else begin expq1.delete(); rx_log1.delete(); end
  endtask

  // One clock: update the model from the inputs seen at the edge, then decode and check.
  task automatic step();
    bit can_pop, full, push, ok;
    logic [7:0] eb;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        occ[k] = 0; free_cyc[k] = 0; stopped[k] = 0; ovf_m[k] = 0;
        rx_act[k] = 0; rx_n[k] = 0; busy_cnt[k] = 0;
        clear_k(k);
      end else begin
        can_pop = (free_cyc[k] == 0) && (occ[k] > 0);
        full    = (occ[k] == DEPTH);
        push    = sample_en && !stopped[k] && !full;
        if (sample_en && !stopped[k] && full) ovf_m[k] = 1;
        if (push) begin
          push_exp(k, 8'hA5);
          push_exp(k, {halt, 3'b000, pc});
          push_exp(k, {r1, r0});
          push_exp(k, {r3, r2});
          push_exp(k, instr);
          if (halt) stopped[k] = 1;
        end
        // a frame holds the line for 50 bit times, then one idle cycle precedes the next pop
        if (can_pop) begin occ[k]--; free_cyc[k] = 50 * cpb[k]; end
        else if (free_cyc[k] > 0) free_cyc[k]--;
        if (push) occ[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rx_act[k]) begin
        rx_cnt[k]++;
        for (int i = 0; i < 8; i++)
          if (rx_cnt[k] == cpb[k] * (1 + i) + cpb[k] / 2) rx_byte[k][i] = tx[k];
        if (rx_cnt[k] == cpb[k] * 9 + cpb[k] / 2) begin
          chk("stop_bit", k, tx[k], 1);
          take_exp(k, eb, ok);
          chk("byte_expected", k, ok, 1);
          if (ok) chk("rx_byte", k, rx_byte[k], eb);
          if (k == 0) rx_log0.push_back(rx_byte[k]); else rx_log1.push_back(rx_byte[k]);
          rx_n[k]++;
          rx_act[k] = 0;
        end
      end else if (tx[k] === 1'b0) begin
        rx_act[k] = 1;
        rx_cnt[k] = 0;
      end
      chk("tx_busy", k, busy[k], free_cyc[k] > 0);
      chk("overflow", k, ovf[k], ovf_m[k]);
      chk("done", k, done[k], stopped[k] && occ[k] == 0 && free_cyc[k] == 0);
      if (free_cyc[k] == 0) chk("tx_idle", k, tx[k], 1);
      if (busy[k] === 1'b1) busy_cnt[k]++;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic drive(input bit en, input bit h);
    sample_en = en; halt = h;
    pc = 4'($urandom); r0 = 4'($urandom); r1 = 4'($urandom);
    r2 = 4'($urandom); r3 = 4'($urandom); instr = 8'($urandom);
  endtask

  task automatic rst_pulse();
    drive(0, 0); rst = 1; step(); rst = 0;
  endtask

  initial begin
    int guard;
    logic [7:0] b;
    bit hseq[8];
    hseq = '{0, 0, 1, 1, 1, 1, 1, 1};

    // reset state
    drive(0, 0);
    rst = 1;
    run_cycles(3);
    for (int k = 0; k < 2; k++) begin
      chk("reset_tx", k, tx[k], 1);
      chk("reset_busy", k, busy[k], 0);
      chk("reset_ovf", k, ovf[k], 0);
      chk("reset_done", k, done[k], 0);
    end
    rst = 0;

    // single record with fixed fields
    sample_en = 1; halt = 0; pc = 4'd3; r0 = 4'd1; r1 = 4'd2; r2 = 4'd3; r3 = 4'd4;
    instr = 8'h5C;
    step();
    sample_en = 0;
    chk("t1_tx_after_sample", 0, tx[0], 1);
    step();
    chk("t1_tx_start", 0, tx[0], 0);
    chk("t1_tx_start", 1, tx[1], 0);
    run_cycles(250);
    chk("t1_busy_len", 0, busy_cnt[0], 200);
    chk("t1_busy_len", 1, busy_cnt[1], 100);
    chk("t1_bytes", 0, rx_n[0], 5);
    chk("t1_bytes", 1, rx_n[1], 5);
    for (int i = 0; i < 5; i++) begin
      b = (i < rx_log0.size()) ? rx_log0[i] : 8'hxx;
      chk("t1_gold", 0, b, gold[i]);
      b = (i < rx_log1.size()) ? rx_log1[i] : 8'hxx;
      chk("t1_gold", 1, b, gold[i]);
    end

    // back-to-back captures overflow the FIFO
    rst_pulse();
    for (int i = 0; i < 12; i++) begin drive(1, 0); step(); end
    drive(0, 0);
    chk("t2_ovf", 0, ovf[0], 1);
    chk("t2_ovf", 1, ovf[1], 1);
    run_cycles(2000);
    for (int k = 0; k < 2; k++) begin
      chk("t2_bytes", k, rx_n[k], 45);
      chk("t2_q_empty", k, exp_size(k), 0);
    end

    // halt stops further capture
    rst_pulse();
    for (int i = 0; i < 8; i++) begin drive(1, hseq[i]); step(); end
    drive(0, 0);
    run_cycles(700);
    for (int k = 0; k < 2; k++) begin
      chk("t3_bytes", k, rx_n[k], 15);
      chk("t3_ovf", k, ovf[k], 0);
      chk("t3_done", k, done[k], 1);
      chk("t3_q_empty", k, exp_size(k), 0);
    end
    b = (rx_log0.size() > 11) ? rx_log0[11] : 8'h00;
    chk("t3_b1_halt", 0, b[7], 1);

    // reset during DATA of B2 with 3 records queued
    rst_pulse();
    for (int i = 0; i < 4; i++) begin drive(1, 0); step(); end
    drive(0, 0);
    run_cycles(90);
    chk("t4_mid_busy", 0, busy[0], 1);
    chk("t4_in_b2", 0, rx_n[0], 2);
    rst = 1; step(); rst = 0;
    chk("t4_tx_rst", 0, tx[0], 1);
    chk("t4_busy_rst", 0, busy[0], 0);
    chk("t4_tx_rst", 1, tx[1], 1);
    chk("t4_busy_rst", 1, busy[1], 0);
    run_cycles(1200);
    chk("t4_silent", 0, rx_n[0], 0);
    chk("t4_silent", 1, rx_n[1], 0);
    drive(1, 0); step(); drive(0, 0);
    run_cycles(300);
    chk("t4_resume", 0, rx_n[0], 5);
    chk("t4_resume", 1, rx_n[1], 5);

    // push on the exact cycle the FSM pops from a full FIFO
    rst_pulse();
    for (int i = 0; i < 9; i++) begin drive(1, 0); step(); end
    drive(0, 0);
    guard = 0;
    while (free_cyc[0] != 0 && guard < 1000) begin step(); guard++; end
    chk("t5_wait_bound", 0, guard < 1000, 1);
    chk("t5_ovf_before", 0, ovf[0], 0);
    drive(1, 0); step(); drive(0, 0);
    chk("t5_ovf_after", 0, ovf[0], 1);
    run_cycles(2000);
    chk("t5_bytes", 0, rx_n[0], 45);
    chk("t5_q_empty", 0, exp_size(0), 0);
    chk("t5_q_empty", 1, exp_size(1), 0);

    // random traffic
    rst_pulse();
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(0, 99) < 20, $urandom_range(0, 299) == 0);
      step();
    end
    drive(0, 0);
    run_cycles(2200);
    chk("t6_q_empty", 0, exp_size(0), 0);
    chk("t6_q_empty", 1, exp_size(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
